// File: rtl/truth_table_capture.sv
// Sweeps every input vector of an N_IN-input combinational gate and packs its sampled output into table_out.
// Optional compare against a reference table is built when TT_COMPARE_EN is defined.
module truth_table_capture #(
   parameter  int N_IN   = 2,
   parameter  int SETTLE = 2,
   localparam int TW     = 1 << N_IN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic [TW-1:0]   table_out
`ifdef TT_COMPARE_EN
   ,
   output logic            match,
   input  logic [TW-1:0]   expected_tbl
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      FIN   = 2'd2
   } state_t;

   localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TW - 1);
   localparam logic [7:0]      CNT_LAST = 8'(SETTLE);

   state_t          state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [TW-1:0]   table_q, table_d;
`ifdef TT_COMPARE_EN
   logic [TW-1:0]   exp_q, exp_d;
   logic            match_q, match_d;
`endif

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      table_d = table_q;
`ifdef TT_COMPARE_EN
      exp_d   = exp_q;
      match_d = match_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DRIVE;
               idx_d   = '0;
               cnt_d   = '0;
               table_d = '0;
`ifdef TT_COMPARE_EN
               exp_d   = expected_tbl;
               match_d = 1'b0;
`endif
            end
         end
         DRIVE: begin
            if (cnt_q == CNT_LAST) begin
               table_d[idx_q] = dut_out;
               if (idx_q == IDX_LAST) begin
                  state_d = FIN;
`ifdef TT_COMPARE_EN
                  // Compare the table including the bit captured this cycle so match lines up with done.
                  match_d = (table_d == exp_q);
`endif
               end else begin
                  idx_d = idx_q + N_IN'(1);
                  cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         table_q <= '0;
`ifdef TT_COMPARE_EN
         exp_q   <= '0;
         match_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         table_q <= table_d;
`ifdef TT_COMPARE_EN
         exp_q   <= exp_d;
         match_q <= match_d;
`endif
      end
   end

   assign busy      = (state_q == DRIVE);
   assign done      = (state_q == FIN);
   assign dut_in    = busy ? idx_q : '0;
   assign table_out = table_q;
`ifdef TT_COMPARE_EN
   assign match     = match_q;
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: a 2-input/SETTLE=2 instance and a 3-input/SETTLE=0 instance, each driving a
// behavioural gate; expected tables are queued at start and checked at done. Compare checks need TT_COMPARE_EN.
module tb_truth_table_capture;

   localparam int S_A   = 2;
   localparam int LAT_A = 4 * (S_A + 1) + 1;
   localparam int S_B   = 0;
   localparam int LAT_B = 8 * (S_B + 1) + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, start_b;
   logic [1:0] dut_in_a;
   logic       dut_out_a, busy_a, done_a;
   logic [3:0] table_a;
   logic [2:0] dut_in_b;
   logic       dut_out_b, busy_b, done_b;
   logic [7:0] table_b;
   logic [3:0] gate_tbl_a;
`ifdef TT_COMPARE_EN
   logic       match_a, match_b;
   logic [3:0] exp_a;
   logic [7:0] exp_b;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] sb_a[$];
   logic [7:0] sb_b[$];

   always #5 clk = ~clk;

   assign dut_out_a = gate_tbl_a[dut_in_a];
   assign dut_out_b = dut_in_b[2] & dut_in_b[0];

   truth_table_capture #(.N_IN(2), .SETTLE(S_A)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
      .busy(busy_a), .done(done_a), .table_out(table_a)
`ifdef TT_COMPARE_EN
      , .match(match_a), .expected_tbl(exp_a)
`endif
   );

   truth_table_capture #(.N_IN(3), .SETTLE(S_B)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
      .busy(busy_b), .done(done_b), .table_out(table_b)
`ifdef TT_COMPARE_EN
      , .match(match_b), .expected_tbl(exp_b)
`endif
   );

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (busy_a !== 1'b0)  begin n_bad++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
      n_cmp++; if (done_a !== 1'b0)  begin n_bad++; $display("FAIL reset_done_a: got %b want 0", done_a); end
      n_cmp++; if (dut_in_a !== 2'd0) begin n_bad++; $display("FAIL reset_dut_in_a: got %0d want 0", dut_in_a); end
      n_cmp++; if (table_a !== 4'd0) begin n_bad++; $display("FAIL reset_table_a: got %b want 0000", table_a); end
      n_cmp++; if ({busy_b, done_b, dut_in_b, table_b} !== 13'd0)
         begin n_bad++; $display("FAIL reset_b: got busy=%b done=%b in=%0d tbl=%b want all 0", busy_b, done_b, dut_in_b, table_b); end
`ifdef TT_COMPARE_EN
      n_cmp++; if ({match_a, match_b} !== 2'b00) begin n_bad++; $display("FAIL reset_match: got %b want 00", {match_a, match_b}); end
`endif
      rst = 1'b0;
   endtask

   // One sweep on instance a; optional stray start pulses during DRIVE (cycle pulse_n) and in the FIN cycle.
   task automatic run_a(input logic [3:0] tbl, input int pulse_n, input bit pulse_fin);
      int         n;
      int         busy_n;
      logic [1:0] exp_in;
      logic [3:0] exp_tbl;
      gate_tbl_a = tbl;
      sb_a.push_back(tbl);
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      n = 1;
      busy_n = 0;
      while (done_a !== 1'b1 && n < 60) begin
         exp_in = 2'((n - 1) / (S_A + 1));
         n_cmp++; if (dut_in_a !== exp_in) begin n_bad++; $display("FAIL dut_in_a cycle %0d: got %0d want %0d", n, dut_in_a, exp_in); end
         if (busy_a === 1'b1) busy_n++;
         start_a = (n == pulse_n);
         @(posedge clk); #1;
         n++;
      end
      start_a = 1'b0;
      n_cmp++; if (n != LAT_A) begin n_bad++; $display("FAIL latency_a: got %0d want %0d", n, LAT_A); end
      n_cmp++; if (busy_n != 4 * (S_A + 1)) begin n_bad++; $display("FAIL busy_len_a: got %0d want %0d", busy_n, 4 * (S_A + 1)); end
      n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL busy_at_done_a: got %b want 0", busy_a); end
      if (sb_a.size() == 0) begin
         n_cmp++; n_bad++; $display("FAIL scoreboard_a: done with no expected entry");
         exp_tbl = 4'd0;
      end else begin
         exp_tbl = sb_a.pop_front();
         n_cmp++; if (table_a !== exp_tbl) begin n_bad++; $display("FAIL table_a: got %b want %b", table_a, exp_tbl); end
      end
      start_a = pulse_fin;
      @(posedge clk); #1;
      start_a = 1'b0;
      n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL done_pulse_a: got %b want 0", done_a); end
      n_cmp++; if (dut_in_a !== 2'd0) begin n_bad++; $display("FAIL dut_in_idle_a: got %0d want 0", dut_in_a); end
      n_cmp++; if (table_a !== exp_tbl) begin n_bad++; $display("FAIL table_hold_a: got %b want %b", table_a, exp_tbl); end
      @(posedge clk); #1;
      n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL idle_busy_a: got %b want 0", busy_a); end
   endtask

   task automatic test_sweep_basic;
      run_a(4'b0100, 0, 1'b0);
   endtask

   task automatic test_patterns;
      run_a(4'b1001, 0, 1'b0);
      run_a(4'b1111, 0, 1'b0);
      run_a(4'b0000, 0, 1'b0);
   endtask

   task automatic test_start_while_busy;
      run_a(4'b0100, 5, 1'b1);
   endtask

   task automatic test_back_to_back;
      int n;
      logic [3:0] exp_tbl;
      gate_tbl_a = 4'b0110;
      sb_a.push_back(4'b0110);
      sb_a.push_back(4'b1001);
      start_a = 1'b1;
      @(posedge clk); #1;
      n = 1;
      while (done_a !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
      n_cmp++; if (n != LAT_A) begin n_bad++; $display("FAIL b2b_latency1: got %0d want %0d", n, LAT_A); end
      exp_tbl = sb_a.pop_front();
      n_cmp++; if (table_a !== exp_tbl) begin n_bad++; $display("FAIL b2b_table1: got %b want %b", table_a, exp_tbl); end
      gate_tbl_a = 4'b1001;
      n = 0;
      @(posedge clk); #1; n++;
      n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap: got busy=%b want 0", busy_a); end
      while (done_a !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
      start_a = 1'b0;
      n_cmp++; if (n != LAT_A + 1) begin n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", n, LAT_A + 1); end
      exp_tbl = sb_a.pop_front();
      n_cmp++; if (table_a !== exp_tbl) begin n_bad++; $display("FAIL b2b_table2: got %b want %b", table_a, exp_tbl); end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL b2b_stop: got busy=%b want 0", busy_a); end
   endtask

   task automatic test_reset_mid;
      int dones;
      gate_tbl_a = 4'b0101;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (table_a !== 4'b0001) begin n_bad++; $display("FAIL partial_table_a: got %b want 0001", table_a); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++; if ({busy_a, done_a, dut_in_a, table_a} !== 8'd0)
         begin n_bad++; $display("FAIL abort_outputs: got busy=%b done=%b in=%0d tbl=%b want all 0", busy_a, done_a, dut_in_a, table_a); end
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done_a === 1'b1 || busy_a === 1'b1) dones++;
      end
      n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL abort_activity: got %0d active cycles want 0", dones); end
      run_a(4'b0100, 0, 1'b0);
   endtask

   task automatic test_n3_settle0;
      int         n;
      logic [7:0] exp_tbl;
      sb_b.push_back(8'b1010_0000);
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      n = 1;
      while (done_b !== 1'b1 && n < 60) begin
         n_cmp++; if (dut_in_b !== 3'(n - 1)) begin n_bad++; $display("FAIL dut_in_b cycle %0d: got %0d want %0d", n, dut_in_b, n - 1); end
         @(posedge clk); #1;
         n++;
      end
      n_cmp++; if (n != LAT_B) begin n_bad++; $display("FAIL latency_b: got %0d want %0d", n, LAT_B); end
      if (sb_b.size() == 0) begin
         n_cmp++; n_bad++; $display("FAIL scoreboard_b: done with no expected entry");
      end else begin
         exp_tbl = sb_b.pop_front();
         n_cmp++; if (table_b !== exp_tbl) begin n_bad++; $display("FAIL table_b: got %b want %b", table_b, exp_tbl); end
      end
      @(posedge clk); #1;
      n_cmp++; if (done_b !== 1'b0) begin n_bad++; $display("FAIL done_pulse_b: got %b want 0", done_b); end
   endtask

`ifdef TT_COMPARE_EN
   task automatic test_compare;
      int n;
      logic want;
      for (int t = 0; t < 2; t++) begin
         want = (t == 0);
         gate_tbl_a = 4'b0100;
         exp_a = (t == 0) ? 4'b0100 : 4'b0010;
         start_a = 1'b1;
         @(posedge clk); #1;
         start_a = 1'b0;
         exp_a = 4'b1111;
         n = 1;
         while (done_a !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
         n_cmp++; if (match_a !== want) begin n_bad++; $display("FAIL match_at_done %0d: got %b want %b", t, match_a, want); end
         @(posedge clk); #1;
         n_cmp++; if (match_a !== want) begin n_bad++; $display("FAIL match_hold %0d: got %b want %b", t, match_a, want); end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      gate_tbl_a = 4'b0000;
`ifdef TT_COMPARE_EN
      exp_a = 4'b0000;
      exp_b = 8'h00;
`endif
      test_reset();
      test_sweep_basic();
      test_patterns();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      test_n3_settle0();
`ifdef TT_COMPARE_EN
      test_compare();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
